// File: rtl/obc_dft_bit_serial_ctrl.sv
// obc_dft_bit_serial_ctrl: bit-serial sequencer feeding 16 sample bit-slices, MSB first,
// to an OBC DA ROM stage and accumulating one DFT bin over valid/ready handshakes.
module obc_dft_bit_serial_ctrl #(
    parameter int WIDTH = 16,
    parameter int ROM_W = 32,
    parameter int OUT_W = ROM_W + WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WIDTH-1:0]   in_data,
    input  logic [ROM_W-1:0]      offset_const,
    output logic [15:0]           slice,
    output logic                  m,
    input  logic [ROM_W-1:0]      rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [15:0][WIDTH-1:0]  sh;
    logic [OUT_W-1:0]        acc, step;
    logic [ROM_W-1:0]        off;
    logic [CW-1:0]           cnt;
    logic                    accept;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        m         = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                m    = cnt == CW'(WIDTH - 1);
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        slice = '0;
        for (int k = 0; k < 16; k++) slice[k] = busy & sh[k][WIDTH-1];
    end

    assign accept = in_valid && in_ready;
    // Shift-and-add: earlier (more significant) slices get doubled on every later step.
    assign step   = (acc << 1) + OUT_W'($signed(rom_data));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            acc      <= '0;
            off      <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sh  <= in_data;
                off <= offset_const;
                acc <= '0;
                cnt <= CW'(WIDTH - 1);
            end else if (state == RUN) begin
                acc <= step;
                for (int k = 0; k < 16; k++) sh[k] <= {sh[k][WIDTH-2:0], 1'b0};
                cnt <= cnt - 1'b1;
                if (cnt == '0) out_data <= step + OUT_W'($signed(off));
            end
        end
    end
endmodule
